wb_master_arbiter: RTL and testbench

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

---
 rtl/soc_wb_pkg.sv | 27 ++
 rtl/wb_rr_pick.sv | 36 +++
 rtl/wb_master_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_master_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_wb_pkg.sv
// Shared definitions for the SoC Wishbone interconnect.
// Holds the default master count, the fixed master index assignments,
// the default bus-stall timeout and the arbiter state encoding.
// No ports: this is a package imported by the arbiter and its helpers.
package soc_wb_pkg;

  // Masters attached to the shared bus, in index order.
  localparam int NUM_MASTERS_DEFAULT    = 3;
  localparam int IBUS                   = 0;
  localparam int DBUS                   = 1;
  localparam int MGMT                   = 2;

  // Stalled cycles tolerated before a bus error is returned (0 = never).
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  // Width of a master index; at least one bit so a single-master bus
  // still has a legal grant register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req        - one request bit per master
//   last_grant - index of the master served most recently
//   winner     - first requester found scanning from last_grant+1, wrapping
//   any_req    - high when at least one request bit is set
// winner is 0 when no request is present; callers qualify it with any_req.
module wb_rr_pick #(
  parameter int N  = 3,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  // Scan starts just after the previous owner so the master that was
  // served last is considered only after everyone else.
  always_comb begin
    int   idx;
    logic found;
    winner  = '0;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_grant) + i) % N;
      if (!found && req[idx]) begin
        winner = IW'(idx);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter that lets several classic Wishbone masters share one
// slave-side bus, with a stall timeout that turns a hung access into an error.
// Ports:
//   i_clk, i_reset               - clock, synchronous active-high reset
//   i_m_cyc/stb/we [N]           - per-master cycle, strobe, write enable
//   i_m_sel [4N], i_m_adr [32N], - per-master byte selects, address, write
//   i_m_dat [32N]                  data; master k occupies slice k
//   o_m_ack/err [N], o_m_dat     - per-master ack/err, broadcast read data
//   o_s_cyc/stb/we/sel/adr/dat   - granted master's request toward slaves
//   i_s_ack, i_s_err, i_s_dat    - slave response
module wb_master_arbiter
  import soc_wb_pkg::*;
#(
  parameter int NUM_MASTERS    = NUM_MASTERS_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_MASTERS-1:0]    i_m_cyc,
  input  logic [NUM_MASTERS-1:0]    i_m_stb,
  input  logic [NUM_MASTERS-1:0]    i_m_we,
  input  logic [4*NUM_MASTERS-1:0]  i_m_sel,
  input  logic [32*NUM_MASTERS-1:0] i_m_adr,
  input  logic [32*NUM_MASTERS-1:0] i_m_dat,
  output logic [NUM_MASTERS-1:0]    o_m_ack,
  output logic [NUM_MASTERS-1:0]    o_m_err,
  output logic [31:0]               o_m_dat,
  output logic                      o_s_cyc,
  output logic                      o_s_stb,
  output logic                      o_s_we,
  output logic [3:0]                o_s_sel,
  output logic [31:0]               o_s_adr,
  output logic [31:0]               o_s_dat,
  input  logic                      i_s_ack,
  input  logic                      i_s_err,
  input  logic [31:0]               i_s_dat
);

  localparam int IW = idx_width(NUM_MASTERS);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t    state, state_next;
  logic [IW-1:0] grant, grant_next;
  logic [IW-1:0] last_grant, last_grant_next;
  logic [CW-1:0] tmo_cnt, tmo_cnt_next;

  logic [IW-1:0] pick_winner;
  logic          pick_any;
  logic          granted;
  logic          grant_cyc;
  logic          live;
  logic          timeout_hit;

  logic [3:0]    m_sel [NUM_MASTERS];
  logic [31:0]   m_adr [NUM_MASTERS];
  logic [31:0]   m_dat [NUM_MASTERS];

  for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
    assign m_sel[k] = i_m_sel[4*k +: 4];
    assign m_adr[k] = i_m_adr[32*k +: 32];
    assign m_dat[k] = i_m_dat[32*k +: 32];
  end

  wb_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req        (i_m_cyc),
    .last_grant (last_grant),
    .winner     (pick_winner),
    .any_req    (pick_any)
  );

  // A transfer is live only while the owner still holds cyc; dropping cyc
  // cuts the slave side off in the same cycle and blocks stray acks.
  assign granted   = (state == ARB_GRANTED);
  assign grant_cyc = i_m_cyc[grant];
  assign live      = granted && grant_cyc;

  assign o_s_cyc = live;
  assign o_s_stb = live && i_m_stb[grant];
  assign o_s_we  = i_m_we[grant];
  assign o_s_sel = m_sel[grant];
  assign o_s_adr = m_adr[grant];
  assign o_s_dat = m_dat[grant];
  assign o_m_dat = i_s_dat;

  // An ack arriving in the very cycle the limit is reached still wins.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && o_s_stb && !i_s_ack &&
                       (tmo_cnt == CW'(TIMEOUT_CYCLES));

  // Responses are routed only to the current owner.
  always_comb begin
    o_m_ack = '0;
    o_m_err = '0;
    if (live) begin
      o_m_ack[grant] = i_s_ack;
      o_m_err[grant] = i_s_err || timeout_hit;
    end
  end

  // The grant is only re-evaluated from IDLE, which gives the one idle
  // cycle between owners and keeps the grant fixed while cyc is held.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_grant_next = last_grant;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          state_next = ARB_GRANTED;
          grant_next = pick_winner;
        end
      end
      ARB_GRANTED: begin
        if (!grant_cyc) begin
          state_next      = ARB_IDLE;
          last_grant_next = grant;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  // Counts consecutive stalled strobe cycles; it clears at the limit, so
  // it cannot wrap.
  always_comb begin
    tmo_cnt_next = '0;
    if ((TIMEOUT_CYCLES != 0) && o_s_stb && !i_s_ack && !i_s_err &&
        !timeout_hit) begin
      tmo_cnt_next = tmo_cnt + CW'(1);
    end
  end

  // last_grant resets to the top index so master 0 is first in line.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= IW'(NUM_MASTERS - 1);
      tmo_cnt    <= '0;
    end else begin
      state      <= state_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
      tmo_cnt    <= tmo_cnt_next;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter (3 masters, 4-cycle timeout).
// A behavioural model tracks ownership and stall length and is compared with
// the DUT every cycle; directed runs add literal expectations per scenario.
module tb_wb_master_arbiter;
  import soc_wb_pkg::*;

  localparam int NM = 3;
  localparam int TO = 4;
  localparam int LOGN = 64;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic [NM-1:0]   i_m_cyc, i_m_stb, i_m_we;
  logic [4*NM-1:0] i_m_sel;
  logic [32*NM-1:0] i_m_adr, i_m_dat;
  logic [NM-1:0]   o_m_ack, o_m_err;
  logic [31:0]     o_m_dat;
  logic            o_s_cyc, o_s_stb, o_s_we;
  logic [3:0]      o_s_sel;
  logic [31:0]     o_s_adr, o_s_dat;
  logic            i_s_ack, i_s_err;
  logic [31:0]     i_s_dat;

  always #5 i_clk = ~i_clk;

  wb_master_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m_cyc(i_m_cyc), .i_m_stb(i_m_stb), .i_m_we(i_m_we),
    .i_m_sel(i_m_sel), .i_m_adr(i_m_adr), .i_m_dat(i_m_dat),
    .o_m_ack(o_m_ack), .o_m_err(o_m_err), .o_m_dat(o_m_dat),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_sel(o_s_sel), .o_s_adr(o_s_adr), .o_s_dat(o_s_dat),
    .i_s_ack(i_s_ack), .i_s_err(i_s_err), .i_s_dat(i_s_dat)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
  endtask

  // Per-master request contents.
  logic [31:0] cfg_adr [NM];
  logic [31:0] cfg_dat [NM];
  logic        cfg_we  [NM];
  logic [3:0]  cfg_sel [NM];

  task automatic setMaster(input int k, input logic on);
    i_m_cyc[k]        = on;
    i_m_stb[k]        = on;
    i_m_we[k]         = cfg_we[k];
    i_m_sel[4*k +: 4]  = cfg_sel[k];
    i_m_adr[32*k +: 32] = cfg_adr[k];
    i_m_dat[32*k +: 32] = cfg_dat[k];
  endtask

  // Slave: acks when the strobe has been waiting ack_delay cycles
  // (0 = same cycle as the strobe rises); ack_delay < 0 never acks.
  int   ack_delay = 0;
  int   slv_cnt = 0;
  logic slv_stall_prev = 1'b0;
  initial begin
    i_s_ack = 1'b0;
    i_s_dat = 32'h0;
    forever begin
      @(posedge i_clk);
      #2;
      if (i_reset || !slv_stall_prev) slv_cnt = 0;
      else slv_cnt++;
      i_s_ack = (ack_delay >= 0) && o_s_stb && (slv_cnt == ack_delay);
      i_s_dat = $urandom;
      @(negedge i_clk);
      slv_stall_prev = o_s_stb && !i_s_ack && !i_s_err;
    end
  end

  // ---------------- behavioural model ----------------
  logic mdl_valid = 1'b0;
  logic mdl_granted = 1'b0;
  int   mdl_grant = 0;
  int   mdl_last = NM - 1;
  int   mdl_stall = 0;

  function automatic int pickNext(input logic [NM-1:0] req, input int last);
    for (int s = 1; s <= NM; s++) begin
      if (req[(last + s) % NM]) return (last + s) % NM;
    end
    return 0;
  endfunction

  function automatic logic expLive();
    return mdl_granted && i_m_cyc[mdl_grant];
  endfunction

  function automatic logic expStb();
    return expLive() && i_m_stb[mdl_grant];
  endfunction

  function automatic logic expTimeout();
    return (TO != 0) && expStb() && (mdl_stall == TO) && !i_s_ack;
  endfunction

  function automatic logic [NM-1:0] expAck();
    logic [NM-1:0] v;
    v = '0;
    if (expLive()) v[mdl_grant] = i_s_ack;
    return v;
  endfunction

  function automatic logic [NM-1:0] expErr();
    logic [NM-1:0] v;
    v = '0;
    if (expLive()) v[mdl_grant] = i_s_err | expTimeout();
    return v;
  endfunction

  always @(posedge i_clk) begin
    if (i_reset) begin
      mdl_valid   <= 1'b1;
      mdl_granted <= 1'b0;
      mdl_last    <= NM - 1;
      mdl_stall   <= 0;
    end else if (!mdl_granted) begin
      mdl_stall <= 0;
      if (|i_m_cyc) begin
        mdl_granted <= 1'b1;
        mdl_grant   <= pickNext(i_m_cyc, mdl_last);
      end
    end else begin
      if (expStb() && !i_s_ack && !i_s_err && !expTimeout())
        mdl_stall <= mdl_stall + 1;
      else
        mdl_stall <= 0;
      if (!i_m_cyc[mdl_grant]) begin
        mdl_granted <= 1'b0;
        mdl_last    <= mdl_grant;
      end
    end
  end

  always @(negedge i_clk) begin
    if (mdl_valid) begin
      checkOutput("s_cyc", 32'(o_s_cyc), 32'(expLive()));
      checkOutput("s_stb", 32'(o_s_stb), 32'(expStb()));
      checkOutput("m_ack", 32'(o_m_ack), 32'(expAck()));
      checkOutput("m_err", 32'(o_m_err), 32'(expErr()));
      checkOutput("m_dat", o_m_dat, i_s_dat);
      if (expLive()) begin
        checkOutput("s_we",  32'(o_s_we),  32'(i_m_we[mdl_grant]));
        checkOutput("s_sel", 32'(o_s_sel), 32'(i_m_sel[4*mdl_grant +: 4]));
        checkOutput("s_adr", o_s_adr, i_m_adr[32*mdl_grant +: 32]);
        checkOutput("s_dat", o_s_dat, i_m_dat[32*mdl_grant +: 32]);
      end
    end
  end

  // ---------------- directed runs ----------------
  logic          lg_scyc [LOGN];
  logic          lg_we   [LOGN];
  logic [3:0]    lg_sel  [LOGN];
  logic [31:0]   lg_adr  [LOGN];
  logic [31:0]   lg_dat  [LOGN];
  logic [NM-1:0] lg_ack  [LOGN];
  logic [NM-1:0] lg_err  [LOGN];
  int            lg_len;

  task automatic doReset();
    applyStimulus();
    i_reset = 1'b1;
    for (int k = 0; k < NM; k++) setMaster(k, 1'b0);
    applyStimulus();
    i_reset = 1'b0;
  endtask

  // Each master performs its quota of single transfers, dropping cyc the
  // cycle after it sees ack or err and re-requesting the cycle after that.
  // Cycle 0 of the log is the cycle the first requests are raised.
  task automatic runMasters(input int r0, input int r1, input int r2,
                            input int budget);
    int   remaining [NM];
    logic active [NM];
    logic seen [NM];
    logic busy;
    int   c;
    remaining = '{r0, r1, r2};
    for (int k = 0; k < NM; k++) begin
      active[k] = 1'b0;
      seen[k]   = 1'b0;
    end
    lg_len = 0;
    c = 0;
    busy = 1'b1;
    while (busy && c < budget) begin
      applyStimulus();
      for (int k = 0; k < NM; k++) begin
        if (active[k] && seen[k]) begin
          setMaster(k, 1'b0);
          active[k] = 1'b0;
          remaining[k]--;
        end else if (!active[k] && remaining[k] > 0) begin
          setMaster(k, 1'b1);
          active[k] = 1'b1;
        end
      end
      @(negedge i_clk);
      for (int k = 0; k < NM; k++) seen[k] = o_m_ack[k] | o_m_err[k];
      if (c < LOGN) begin
        lg_scyc[c] = o_s_cyc;
        lg_we[c]   = o_s_we;
        lg_sel[c]  = o_s_sel;
        lg_adr[c]  = o_s_adr;
        lg_dat[c]  = o_s_dat;
        lg_ack[c]  = o_m_ack;
        lg_err[c]  = o_m_err;
        lg_len     = c + 1;
      end
      c++;
      busy = 1'b0;
      for (int k = 0; k < NM; k++)
        if (active[k] || remaining[k] > 0) busy = 1'b1;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL run_budget: transfers still pending after %0d cycles, required none", budget);
    end
  endtask

  initial begin
    int rise_at [4];
    int who [4];
    int cnt;

    i_reset = 1'b1;
    i_s_err = 1'b0;
    i_m_cyc = '0; i_m_stb = '0; i_m_we = '0;
    i_m_sel = '0; i_m_adr = '0; i_m_dat = '0;
    for (int k = 0; k < NM; k++) begin
      cfg_adr[k] = 32'h1000_0000 + 32'(k) * 32'h100;
      cfg_dat[k] = 32'hC0DE_0000 + 32'(k);
      cfg_we[k]  = 1'b0;
      cfg_sel[k] = 4'hF;
    end
    applyStimulus();
    applyStimulus();
    i_reset = 1'b0;
    @(negedge i_clk);
    checkOutput("reset_s_cyc", 32'(o_s_cyc), 32'h0);
    checkOutput("reset_s_stb", 32'(o_s_stb), 32'h0);
    checkOutput("reset_m_ack", 32'(o_m_ack), 32'h0);
    checkOutput("reset_m_err", 32'(o_m_err), 32'h0);

    // All three request together: master 0 first, one cycle late.
    $display("[TB] all masters requesting after reset");
    doReset();
    ack_delay = 0;
    runMasters(1, 1, 1, 40);
    checkOutput("allreq_c0_s_cyc", 32'(lg_scyc[0]), 32'h0);
    checkOutput("allreq_c1_s_cyc", 32'(lg_scyc[1]), 32'h1);
    checkOutput("allreq_c1_adr",   lg_adr[1], 32'h1000_0000);
    checkOutput("allreq_c4_adr",   lg_adr[4], 32'h1000_0100);

    // Masters 0 and 1 alternate single reads, ack two cycles after strobe.
    $display("[TB] back-to-back reads from masters 0 and 1");
    doReset();
    ack_delay = 2;
    runMasters(2, 2, 0, 60);
    rise_at = '{1, 6, 11, 16};
    who     = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      checkOutput("rr_before_rise", 32'(lg_scyc[rise_at[i]-1]), 32'h0);
      checkOutput("rr_rise",        32'(lg_scyc[rise_at[i]]), 32'h1);
      checkOutput("rr_owner_adr",   lg_adr[rise_at[i]], 32'h1000_0000 + 32'(who[i]) * 32'h100);
      if (i > 0) begin
        checkOutput("rr_gap_low", 32'(lg_scyc[rise_at[i]-2]), 32'h0);
        checkOutput("rr_gap_end", 32'(lg_scyc[rise_at[i]-3]), 32'h1);
      end
    end

    // Master 1 write while master 2 waits its turn.
    $display("[TB] master 1 write with master 2 pending");
    cfg_we[1]  = 1'b1;
    cfg_adr[1] = 32'h3000_1004;
    cfg_dat[1] = 32'hDEAD_BEEF;
    cfg_sel[1] = 4'hF;
    cfg_sel[2] = 4'h3;
    doReset();
    ack_delay = 1;
    runMasters(0, 1, 1, 40);
    checkOutput("wr_we",  32'(lg_we[1]),  32'h1);
    checkOutput("wr_adr", lg_adr[1], 32'h3000_1004);
    checkOutput("wr_dat", lg_dat[1], 32'hDEAD_BEEF);
    checkOutput("wr_sel", 32'(lg_sel[1]), 32'hF);
    checkOutput("wr_ack1", 32'(lg_ack[2]), 32'h2);
    for (int i = 0; i < 6; i++)
      checkOutput("wr_m2_ack_wait", 32'(lg_ack[i][2]), 32'h0);
    checkOutput("m2_adr", lg_adr[5], 32'h1000_0200);
    checkOutput("m2_ack", 32'(lg_ack[6]), 32'h4);

    // Slave never answers: one error pulse four cycles after strobe.
    $display("[TB] timeout with silent slave");
    doReset();
    ack_delay = -1;
    runMasters(1, 0, 0, 40);
    checkOutput("tmo_c4_err", 32'(lg_err[4]), 32'h0);
    checkOutput("tmo_c5_err", 32'(lg_err[5]), 32'h1);
    cnt = 0;
    for (int i = 0; i < lg_len; i++) cnt += $countones(lg_err[i]);
    checkOutput("tmo_err_pulses", 32'(cnt), 32'h1);
    cnt = 0;
    for (int i = 0; i < lg_len; i++) cnt += $countones(lg_ack[i]);
    checkOutput("tmo_no_ack", 32'(cnt), 32'h0);

    // Ack lands in the same cycle the limit is reached: ack wins.
    $display("[TB] ack coinciding with timeout");
    doReset();
    ack_delay = 4;
    runMasters(1, 0, 0, 40);
    checkOutput("race_ack", 32'(lg_ack[5]), 32'h1);
    cnt = 0;
    for (int i = 0; i < lg_len; i++) cnt += $countones(lg_err[i]);
    checkOutput("race_no_err", 32'(cnt), 32'h0);

    // Reset while master 2 owns the bus.
    $display("[TB] reset during master 2 transfer");
    doReset();
    ack_delay = -1;
    applyStimulus();
    setMaster(2, 1'b1);
    @(negedge i_clk);
    applyStimulus();
    @(negedge i_clk);
    checkOutput("rst_m2_cyc", 32'(o_s_cyc), 32'h1);
    checkOutput("rst_m2_adr", o_s_adr, 32'h1000_0200);
    applyStimulus();
    i_reset = 1'b1;
    setMaster(0, 1'b1);
    setMaster(1, 1'b1);
    @(negedge i_clk);
    applyStimulus();
    i_reset = 1'b0;
    @(negedge i_clk);
    checkOutput("rst_after_cyc", 32'(o_s_cyc), 32'h0);
    checkOutput("rst_after_stb", 32'(o_s_stb), 32'h0);
    checkOutput("rst_after_ack", 32'(o_m_ack), 32'h0);
    checkOutput("rst_after_err", 32'(o_m_err), 32'h0);
    applyStimulus();
    @(negedge i_clk);
    checkOutput("rst_regrant_cyc", 32'(o_s_cyc), 32'h1);
    checkOutput("rst_regrant_adr", o_s_adr, 32'h1000_0000);
    applyStimulus();
    for (int k = 0; k < NM; k++) setMaster(k, 1'b0);
    applyStimulus();
    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
